// File: rtl/anb_wr_burst_chopper.sv
// rtl/anb_wr_burst_chopper.sv - splits ANB write bursts into bounded, boundary-safe sub-bursts
// and regenerates last on the data channel at every sub-burst end.
module anb_wr_burst_chopper #(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int DATA_W         = 64,
  parameter int MAX_BEATS      = 16,
  parameter int BOUNDARY_BYTES = 4096,
  parameter int LQ_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_avalid,
  output logic              m_aready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [LEN_W-1:0]  m_len,
  output logic              s_avalid,
  input  logic              s_aready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [LEN_W-1:0]  s_len,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [DATA_W-1:0] m_data,
  input  logic              m_last,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  output logic              err_last
);
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BB_W       = $clog2(BEAT_BYTES);
  localparam int BND_BEATS  = BOUNDARY_BYTES / BEAT_BYTES;
  localparam int CW         = LEN_W + 1;
  localparam int PW         = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  typedef enum logic {IDLE, SPLIT} state_t;
  typedef logic [PW:0] cnt_t;

  state_t            state_q, state_d;
  logic              rdy_q;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, s_addr_q, s_addr_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [LEN_W-1:0]  s_len_q, s_len_d;
  logic              s_avalid_q, s_avalid_d;
  logic [CW-1:0]     lq_mem_q [LQ_DEPTH];
  logic [CW-1:0]     lq_mem_d [LQ_DEPTH];
  logic [CW-1:0]     oq_mem_q [LQ_DEPTH];
  logic [CW-1:0]     oq_mem_d [LQ_DEPTH];
  logic [PW-1:0]     lq_wp_q, lq_wp_d, lq_rp_q, lq_rp_d;
  logic [PW-1:0]     oq_wp_q, oq_wp_d, oq_rp_q, oq_rp_d;
  cnt_t              lq_cnt_q, lq_cnt_d, oq_cnt_q, oq_cnt_d;
  logic [LEN_W-1:0]  bcnt_q, bcnt_d, obeat_q, obeat_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] bnd_off;
  logic [31:0]       to_bnd;
  logic [CW-1:0]     chunk, lq_head, oq_head;
  logic              lq_full, lq_nempty, oq_full, a_fire, s_fire, beat, o_final;

  // Beats left before the boundary bound the chunk along with rem and MAX_BEATS.
  always_comb begin
    bnd_off = (cur_addr_q & ADDR_W'(BOUNDARY_BYTES - 1)) >> BB_W;
    to_bnd  = 32'(BND_BEATS) - 32'(bnd_off);
    chunk   = rem_q;
    if (chunk > CW'(MAX_BEATS)) chunk = CW'(MAX_BEATS);
    if (32'(chunk) > to_bnd) chunk = CW'(to_bnd);
  end

  assign lq_head   = lq_mem_q[lq_rp_q];
  assign oq_head   = oq_mem_q[oq_rp_q];
  assign lq_full   = (lq_cnt_q == cnt_t'(LQ_DEPTH));
  assign oq_full   = (oq_cnt_q == cnt_t'(LQ_DEPTH));
  assign lq_nempty = (lq_cnt_q != '0);

  assign m_aready = rdy_q & (state_q == IDLE) & ~oq_full;
  assign a_fire   = m_avalid & m_aready;
  assign s_fire   = s_avalid_q & s_aready;
  assign s_avalid = s_avalid_q;
  assign s_addr   = s_addr_q;
  assign s_len    = s_len_q;

  assign s_valid  = m_valid & lq_nempty;
  assign m_ready  = s_ready & lq_nempty;
  assign s_data   = m_data;
  assign beat     = s_valid & s_ready;
  assign s_last   = lq_nempty & ({1'b0, bcnt_q} == lq_head - CW'(1));
  assign o_final  = ({1'b0, obeat_q} == oq_head - CW'(1));
  assign err_last = err_q;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    s_avalid_d = s_avalid_q;
    s_addr_d   = s_addr_q;
    s_len_d    = s_len_q;
    case (state_q)
      IDLE: begin
        if (a_fire) begin
          cur_addr_d = m_addr;
          rem_d      = {1'b0, m_len} + CW'(1);
          state_d    = SPLIT;
        end
      end
      SPLIT: begin
        if (s_fire) begin
          s_avalid_d = 1'b0;
          cur_addr_d = cur_addr_q + (ADDR_W'(chunk) << BB_W);
          rem_d      = rem_q - chunk;
          if (rem_q == chunk) state_d = IDLE;
        end else if (!s_avalid_q && !lq_full) begin
          s_avalid_d = 1'b1;
          s_addr_d   = cur_addr_q;
          s_len_d    = LEN_W'(chunk - CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lq_mem_d = lq_mem_q;
    oq_mem_d = oq_mem_q;
    lq_wp_d  = lq_wp_q;
    lq_rp_d  = lq_rp_q;
    oq_wp_d  = oq_wp_q;
    oq_rp_d  = oq_rp_q;
    bcnt_d   = bcnt_q;
    obeat_d  = obeat_q;
    err_d    = err_q;
    if (s_fire) begin
      lq_mem_d[lq_wp_q] = chunk;
      lq_wp_d           = lq_wp_q + PW'(1);
    end
    if (a_fire) begin
      oq_mem_d[oq_wp_q] = {1'b0, m_len} + CW'(1);
      oq_wp_d           = oq_wp_q + PW'(1);
    end
    if (beat) begin
      bcnt_d  = s_last ? '0 : bcnt_q + LEN_W'(1);
      obeat_d = o_final ? '0 : obeat_q + LEN_W'(1);
      if (s_last) lq_rp_d = lq_rp_q + PW'(1);
      if (o_final) oq_rp_d = oq_rp_q + PW'(1);
      if (m_last != o_final) err_d = 1'b1;
    end
    lq_cnt_d = lq_cnt_q + cnt_t'(s_fire) - cnt_t'(beat & s_last);
    oq_cnt_d = oq_cnt_q + cnt_t'(a_fire) - cnt_t'(beat & o_final);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      cur_addr_q <= '0;
      rem_q      <= '0;
      s_avalid_q <= 1'b0;
      s_addr_q   <= '0;
      s_len_q    <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_mem_q[i] <= '0;
        oq_mem_q[i] <= '0;
      end
      lq_wp_q    <= '0;
      lq_rp_q    <= '0;
      oq_wp_q    <= '0;
      oq_rp_q    <= '0;
      lq_cnt_q   <= '0;
      oq_cnt_q   <= '0;
      bcnt_q     <= '0;
      obeat_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      s_avalid_q <= s_avalid_d;
      s_addr_q   <= s_addr_d;
      s_len_q    <= s_len_d;
      lq_mem_q   <= lq_mem_d;
      oq_mem_q   <= oq_mem_d;
      lq_wp_q    <= lq_wp_d;
      lq_rp_q    <= lq_rp_d;
      oq_wp_q    <= oq_wp_d;
      oq_rp_q    <= oq_rp_d;
      lq_cnt_q   <= lq_cnt_d;
      oq_cnt_q   <= oq_cnt_d;
      bcnt_q     <= bcnt_d;
      obeat_q    <= obeat_d;
      err_q      <= err_d;
    end
  end
endmodule
